// File: rtl/rs_age_issue.sv
`default_nettype none
// ============================================================================
// Module   : rs_age_issue
// Purpose  : Reservation station with age-ordered issue. Holds up to
//            NUM_ENTRIES renamed operations, wakes source tags from NUM_CDB
//            broadcast buses, and issues the oldest ready entry over a
//            valid/ready handshake. A flush clears the whole station.
// Ports    : clk, reset (async, active-high)
//            disp_*      - dispatch request/handshake and operation fields
//            cdb_valid/cdb_tag - per-port tag broadcast, port p at
//                          cdb_tag[p*TAG_W +: TAG_W]
//            flush       - clears every entry at the next edge
//            issue_*     - selected entry and issue handshake
//            occupancy   - number of busy entries
// Revision : 1.0 - initial release
// ============================================================================
module rs_age_issue #(
    parameter int NUM_ENTRIES = 8,
    parameter int TAG_W       = 6,
    parameter int OP_W        = 7,
    parameter int NUM_CDB     = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               disp_valid,
    output logic                               disp_ready,
    input  logic [OP_W-1:0]                    disp_op,
    input  logic [TAG_W-1:0]                   disp_t,
    input  logic [TAG_W-1:0]                   disp_t1,
    input  logic [TAG_W-1:0]                   disp_t2,
    input  logic                               disp_t1_rdy,
    input  logic                               disp_t2_rdy,
    input  logic [NUM_CDB-1:0]                 cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]           cdb_tag,
    input  logic                               flush,
    output logic                               issue_valid,
    input  logic                               issue_ready,
    output logic [OP_W-1:0]                    issue_op,
    output logic [TAG_W-1:0]                   issue_t,
    output logic [TAG_W-1:0]                   issue_t1,
    output logic [TAG_W-1:0]                   issue_t2,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

    localparam int                 c_OCC_W   = $clog2(NUM_ENTRIES + 1);
    localparam logic [c_OCC_W-1:0] c_OCC_MAX = c_OCC_W'(NUM_ENTRIES);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);

    // Per-entry state
    logic [NUM_ENTRIES-1:0] r_busy;
    logic [NUM_ENTRIES-1:0] r_r1;
    logic [NUM_ENTRIES-1:0] r_r2;
    logic [OP_W-1:0]        r_op [NUM_ENTRIES];
    logic [TAG_W-1:0]       r_t  [NUM_ENTRIES];
    logic [TAG_W-1:0]       r_t1 [NUM_ENTRIES];
    logic [TAG_W-1:0]       r_t2 [NUM_ENTRIES];
    // r_older[i][j] = 1 means entry j was dispatched before entry i
    logic [NUM_ENTRIES-1:0] r_older [NUM_ENTRIES];
    logic [c_OCC_W-1:0]     r_occ;

    logic [NUM_ENTRIES-1:0] w_ready;
    logic [NUM_ENTRIES-1:0] w_sel;
    logic [NUM_ENTRIES-1:0] w_issue_oh;
    logic [NUM_ENTRIES-1:0] w_disp_oh;
    logic [NUM_ENTRIES-1:0] w_wake1;
    logic [NUM_ENTRIES-1:0] w_wake2;
    logic                   w_byp1;
    logic                   w_byp2;
    logic                   w_free_found;
    logic                   w_disp_fire;
    logic                   w_issue_fire;

    assign occupancy    = r_occ;
    assign disp_ready   = (r_occ < c_OCC_MAX);
    assign w_ready      = r_busy & r_r1 & r_r2;
    assign issue_valid  = (|w_ready) && !flush;
    assign w_disp_fire  = disp_valid && disp_ready && !flush;
    assign w_issue_fire = issue_valid && issue_ready;
    assign w_issue_oh   = w_sel & {NUM_ENTRIES{issue_valid}};

    // Oldest ready entry: ready, and no other ready entry is older. Stale
    // older bits pointing at free slots are masked by w_ready.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_sel[i] = w_ready[i] && ((r_older[i] & w_ready) == '0);
        end
    end

    // Lowest-index free slot as a one-hot vector
    always_comb begin
        w_disp_oh    = '0;
        w_free_found = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!r_busy[i] && !w_free_found) begin
                w_disp_oh[i] = 1'b1;
                w_free_found = 1'b1;
            end
        end
    end

    // Tag matches against stored sources and the incoming dispatch sources
    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        w_byp1  = 1'b0;
        w_byp2  = 1'b0;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (cdb_valid[p]) begin
                if (cdb_tag[p*TAG_W +: TAG_W] == disp_t1) w_byp1 = 1'b1;
                if (cdb_tag[p*TAG_W +: TAG_W] == disp_t2) w_byp2 = 1'b1;
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (cdb_tag[p*TAG_W +: TAG_W] == r_t1[i]) w_wake1[i] = 1'b1;
                    if (cdb_tag[p*TAG_W +: TAG_W] == r_t2[i]) w_wake2[i] = 1'b1;
                end
            end
        end
    end

    // Issue field mux; one-hot select gated so fields read 0 when idle
    always_comb begin
        issue_op = '0;
        issue_t  = '0;
        issue_t1 = '0;
        issue_t2 = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_issue_oh[i]) begin
                issue_op = issue_op | r_op[i];
                issue_t  = issue_t  | r_t[i];
                issue_t1 = issue_t1 | r_t1[i];
                issue_t2 = issue_t2 | r_t2[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
            r_r1   <= '0;
            r_r2   <= '0;
            r_occ  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_op[i]    <= '0;
                r_t[i]     <= '0;
                r_t1[i]    <= '0;
                r_t2[i]    <= '0;
                r_older[i] <= '0;
            end
        end else if (flush) begin
            r_busy <= '0;
            r_r1   <= '0;
            r_r2   <= '0;
            r_occ  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                // The dispatch slot is free and the issue slot is busy, so
                // at most one of these branches applies to an entry.
                if (w_issue_fire && w_sel[i]) begin
                    r_busy[i] <= 1'b0;
                    r_r1[i]   <= 1'b0;
                    r_r2[i]   <= 1'b0;
                end else if (w_disp_fire && w_disp_oh[i]) begin
                    r_busy[i] <= 1'b1;
                    r_op[i]   <= disp_op;
                    r_t[i]    <= disp_t;
                    r_t1[i]   <= disp_t1;
                    r_t2[i]   <= disp_t2;
                    r_r1[i]   <= disp_t1_rdy || w_byp1;
                    r_r2[i]   <= disp_t2_rdy || w_byp2;
                end else if (r_busy[i]) begin
                    r_r1[i]   <= r_r1[i] || w_wake1[i];
                    r_r2[i]   <= r_r2[i] || w_wake2[i];
                end

                // New entry is younger than every busy entry; its own bit in
                // r_busy is 0, so the row write leaves older[k][k] clear.
                if (w_disp_fire) begin
                    if (w_disp_oh[i]) begin
                        r_older[i] <= r_busy;
                    end else begin
                        r_older[i] <= r_older[i] & ~w_disp_oh;
                    end
                end
            end

            case ({w_disp_fire, w_issue_fire})
                2'b10:   r_occ <= r_occ + c_OCC_ONE;
                2'b01:   r_occ <= r_occ - c_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rs_age_issue.md
# rs_age_issue

Parametrised reservation station between rename/dispatch and the functional-unit issue port. It holds up to NUM_ENTRIES renamed operations and wakes up source tags from NUM_CDB common data buses. It issues the oldest ready entry each cycle over a valid/ready handshake and supports a full-pipeline flush. It replaces the single-CDB, index-priority station with age-ordered issue, dispatch-time bypass and back-pressure in both directions.

## Interface
Parameters:
- NUM_ENTRIES, 8, station depth (≥2)
- TAG_W, 6, physical-register tag width
- OP_W, 7, opcode width
- NUM_CDB, 2, number of CDB broadcast ports (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept dispatch
- disp_op  in  OP_W  opcode
- disp_t  in  TAG_W  destination tag
- disp_t1, disp_t2  in  TAG_W each  source tags
- disp_t1_rdy, disp_t2_rdy  in  1 each  source already available (map-table valid, or no source)
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  per-port tag, port p at bits [p*TAG_W +: TAG_W]
- flush  in  1  precise-state recovery, clears station
- issue_valid  out  1  an entry is ready to issue
- issue_ready  in  1  functional unit accepts
- issue_op  out  OP_W; issue_t, issue_t1, issue_t2  out  TAG_W each  selected entry fields
- occupancy  out  $clog2(NUM_ENTRIES+1)  number of busy entries

## Operation
- Per-entry state: busy, op, t, t1, t2, r1, r2, plus an age matrix older[i][j] (1 = entry j is older than entry i).
- Dispatch fires when disp_valid && disp_ready && !flush. It writes the lowest-index non-busy entry k and sets busy. It sets older[k][j] = busy[j] for all j≠k and clears older[j][k] for all j.
- Dispatch bypass: r1 is written as disp_t1_rdy OR (any p: cdb_valid[p] && cdb_tag[p]==disp_t1). r2 follows the same rule for disp_t2.
- Wakeup: for every busy entry and every port p with cdb_valid[p], a tag match on t1 sets r1, and a tag match on t2 sets r2. Multiple ports matching the same tag are harmless.
- Ready(i) = busy && r1 && r2, computed from registered state only. A CDB tag reaches issue no earlier than the cycle after broadcast.
- Select: the chosen entry is the ready entry i with no ready entry j where older[i][j]=1. It is unique, and it is the oldest ready entry.
- issue_valid = any ready && !flush. The issue_* fields show the selected entry and are 0 when issue_valid=0.
- Issue fires when issue_valid && issue_ready. The selected entry is cleared (busy=0, r1=r2=0) at the edge.
- Selection is recomputed every cycle. If the consumer stalls, a newly woken older entry may replace the presented one, so the consumer must not assume the fields stay stable.
- disp_ready = (occupancy < NUM_ENTRIES), from registered occupancy. A slot freed by issue in cycle N is available to dispatch in cycle N+1.
- Occupancy next value is occupancy + dispatch − issue. Simultaneous dispatch and issue leaves it unchanged.
- Flush has priority. At the next edge every entry is cleared and occupancy goes to 0. Dispatch and issue are both suppressed in the flush cycle.

## Timing
- Reset (async assert) sets all busy/r1/r2/older to 0, occupancy=0, disp_ready=1, issue_valid=0 and issue_* =0. The outputs take these values immediately, with no clock needed.
- Dispatch-to-issue latency is 1 cycle minimum. An entry dispatched at edge N with both sources ready can present issue_valid in cycle N+1.
- CDB-to-issue latency is 1 cycle. A broadcast in cycle N sets r at edge N; the entry can issue in cycle N+1.
- Same-cycle dispatch bypass plus broadcast behaves exactly like a dispatch with rdy=1.
- Full: disp_ready=0. A disp_valid held high while full is not lost; it fires the cycle after an issue.
- Reset asserted mid-operation discards all entries with no partial state retained. issue_valid stays 0 until the first post-reset dispatch edge plus 1 cycle.

## Test plan
- Reset, then dispatch {op=3,t=5,t1=1,t2=2, both rdy=1} with issue_ready=1. Expected: issue_valid=1 in the next cycle, issue_t=5, occupancy 1→0.
- Age order: dispatch A(t=10) then B(t=11), both waiting on tag 7; broadcast cdb_tag=7. Expected: next cycle issues A, then B, regardless of slot indices (pre-fragment slots so B lands at a lower index than A).
- Bypass: dispatch with disp_t1=9, disp_t1_rdy=0, while cdb_valid[1]=1, cdb_tag[1]=9, and t2 ready. Expected: issue_valid=1 in the next cycle.
- Full/backpressure: with issue_ready=0, fill NUM_ENTRIES=8 entries. Expected: disp_ready=0 and occupancy=8. Then issue one entry; disp_ready=1 the cycle after, and a held dispatch fires.
- Flush: with 5 busy entries, assert flush together with disp_valid and issue_ready. Expected: no issue handshake, and occupancy=0, issue_valid=0 on the next cycle.
- Dual CDB: broadcast tags 3 and 4 on ports 0 and 1 in the same cycle, to an entry waiting on t1=3, t2=4. Expected: the entry issues in the next cycle.
